// File: rtl/dshot_pkg.sv
// Shared DShot definitions: field widths, scheduler states and the CRC helper.
package dshot_pkg;

  localparam int DSHOT_THROTTLE_W = 11;
  localparam int DSHOT_PKT_W      = 16;
  localparam int DSHOT_CMD_MAX    = 47;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} dshot_state_t;

  // One motor's command word as held in the shadow and active banks.
  typedef struct packed {
    logic [DSHOT_THROTTLE_W-1:0] throttle;
    logic                        tlm;
  } dshot_cmd_t;

  // DShot checksum: XOR of the three nibbles of the 12-bit payload.
  function automatic logic [3:0] dshot_crc(input logic [11:0] d12);
    return d12[11:8] ^ d12[7:4] ^ d12[3:0];
  endfunction

endpackage

// File: rtl/dshot_pkt_former.sv
// Combinational DShot packet builder: payload plus checksum, forced to zero when disarmed.
module dshot_pkt_former
  import dshot_pkg::*;
(
  input  logic [DSHOT_THROTTLE_W-1:0] i_throttle,
  input  logic                        i_tlm,
  input  logic                        i_arm,
  output logic [DSHOT_PKT_W-1:0]      o_packet
);

  logic [11:0] w_d12;

  // Disarmed motors always get throttle 0 / no telemetry, with a matching checksum.
  always_comb begin
    w_d12 = 12'd0;
    if (i_arm) begin
      w_d12 = {i_throttle, i_tlm};
    end
    o_packet = {w_d12, dshot_crc(w_d12)};
  end

endmodule

// File: rtl/dshot_scheduler.sv
// Round-robin scheduler sharing one DShot serializer across NUM_MOTORS channels.
module dshot_scheduler
  import dshot_pkg::*;
#(
  parameter  int NUM_MOTORS   = 4,
  parameter  int FRAME_PERIOD = 2000,
  parameter  int GAP_CYCLES   = 2,
  parameter  int TIMEOUT      = 255,
  localparam int MW           = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [MW-1:0]               wr_addr,
  input  logic [DSHOT_THROTTLE_W-1:0] wr_throttle,
  input  logic                        wr_tlm,
  input  logic                        arm,
  input  logic                        enable,
  input  logic                        ser_done,
  output logic                        ser_load,
  output logic [DSHOT_PKT_W-1:0]      ser_data,
  output logic [MW-1:0]               motor_sel,
  output logic                        round_start,
  output logic                        overrun,
  output logic                        timeout_err,
  input  logic                        err_clear
);

  localparam int PW       = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(FRAME_PERIOD - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_END     = GW'(GAP_LAST);
  localparam logic [MW-1:0] MOTOR_LAST  = MW'(NUM_MOTORS - 1);

  dshot_cmd_t                r_shadow [NUM_MOTORS];
  dshot_cmd_t                r_active [NUM_MOTORS];
  dshot_state_t              r_state;
  logic [PW-1:0]             r_periodCnt;
  logic [TW-1:0]             r_waitCnt;
  logic [GW-1:0]             r_gapCnt;
  logic [MW-1:0]             r_motorSel;
  logic                      r_serLoad;
  logic [DSHOT_PKT_W-1:0]    r_serData;
  logic                      r_roundStart;
  logic                      r_overrun;
  logic                      r_timeoutErr;

  logic                      w_tick;
  dshot_cmd_t                w_servedCmd;
  logic [DSHOT_PKT_W-1:0]    w_packet;

  assign w_tick      = (r_periodCnt == PERIOD_LAST);
  assign ser_load    = r_serLoad;
  assign ser_data    = r_serData;
  assign motor_sel   = r_motorSel;
  assign round_start = r_roundStart;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeoutErr;

  // Free-running frame period counter; keeps counting even while disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_periodCnt <= '0;
    end else if (w_tick) begin
      r_periodCnt <= '0;
    end else begin
      r_periodCnt <= r_periodCnt + PW'(1);
    end
  end

  // Shadow bank written by the flight controller; out-of-range indices match no entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NUM_MOTORS; m++) begin
        r_shadow[m] <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_MOTORS; m++) begin
        if (wr_en && (int'(wr_addr) == m)) begin
          r_shadow[m] <= '{throttle: wr_throttle, tlm: wr_tlm};
        end
      end
    end
  end

  // Select the active command of the motor currently being served.
  always_comb begin
    w_servedCmd = '0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      if (r_motorSel == MW'(m)) begin
        w_servedCmd = r_active[m];
      end
    end
  end

  dshot_pkt_former u_pktFormer (
    .i_throttle (w_servedCmd.throttle),
    .i_tlm      (w_servedCmd.tlm),
    .i_arm      (arm),
    .o_packet   (w_packet)
  );

  // Round sequencer: snapshot the shadow bank, then load/wait/gap once per motor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_waitCnt    <= '0;
      r_gapCnt     <= '0;
      r_motorSel   <= '0;
      r_serLoad    <= 1'b0;
      r_serData    <= '0;
      r_roundStart <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeoutErr <= 1'b0;
      for (int m = 0; m < NUM_MOTORS; m++) begin
        r_active[m] <= '0;
      end
    end else begin
      r_serLoad    <= 1'b0;
      r_roundStart <= 1'b0;

      // Clear first so that a set event on the same edge overrides it.
      if (err_clear) begin
        r_overrun    <= 1'b0;
        r_timeoutErr <= 1'b0;
      end
      if (w_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_tick && enable) begin
            for (int m = 0; m < NUM_MOTORS; m++) begin
              r_active[m] <= r_shadow[m];
            end
            r_roundStart <= 1'b1;
            r_motorSel   <= '0;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          r_serLoad <= 1'b1;
          r_serData <= w_packet;
          r_waitCnt <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (ser_done) begin
            r_gapCnt <= '0;
            r_state  <= GAP;
          end else if (r_waitCnt == WAIT_LAST) begin
            r_timeoutErr <= 1'b1;
            r_gapCnt     <= '0;
            r_state      <= GAP;
          end else begin
            r_waitCnt <= r_waitCnt + TW'(1);
          end
        end
        GAP: begin
          if (r_gapCnt == GAP_END) begin
            if (r_motorSel == MOTOR_LAST) begin
              r_state <= IDLE;
            end else begin
              r_motorSel <= r_motorSel + MW'(1);
              r_state    <= LOAD;
            end
          end else begin
            r_gapCnt <= r_gapCnt + GW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dshot_scheduler.sv
// Directed bench for dshot_scheduler: table of per-round packets plus corner-case sequences.
`timescale 1ns/1ps
module tb_dshot_scheduler;

  localparam int NUM_MOTORS = 4;
  localparam int MW         = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [MW-1:0] wr_addr;
  logic [10:0]   wr_throttle;
  logic          wr_tlm;
  logic          arm;
  logic          enable;
  logic          ser_done;
  logic          err_clear;
  logic          ser_load;
  logic [15:0]   ser_data;
  logic [MW-1:0] motor_sel;
  logic          round_start;
  logic          overrun;
  logic          timeout_err;

  int total;
  int bad;

  int serDelay;
  bit serNever;
  bit serBusy;
  int serCnt;

  // One round's worth of commands and the packets each motor must receive.
  // Packed arrays are listed {motor3, motor2, motor1, motor0}.
  typedef struct packed {
    logic [3:0][10:0] thr;
    logic [3:0]       tlm;
    logic             armBit;
    logic [3:0][15:0] expPkt;
  } vec_t;

  vec_t vecs [4];

  dshot_scheduler #(
    .NUM_MOTORS   (NUM_MOTORS),
    .FRAME_PERIOD (50),
    .GAP_CYCLES   (2),
    .TIMEOUT      (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_throttle (wr_throttle),
    .wr_tlm      (wr_tlm),
    .arm         (arm),
    .enable      (enable),
    .ser_done    (ser_done),
    .ser_load    (ser_load),
    .ser_data    (ser_data),
    .motor_sel   (motor_sel),
    .round_start (round_start),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  // 10 ns system clock.
  always #5 clock = ~clock;

  // Serializer stand-in: answers each load with a ser_done pulse serDelay cycles later,
  // or never when serNever is set. Runs on the falling edge to stay clear of the DUT.
  always @(negedge clock) begin
    if (reset) begin
      serBusy  = 1'b0;
      serCnt   = 0;
      ser_done = 1'b0;
    end else begin
      ser_done = 1'b0;
      if (serBusy) begin
        if (serCnt <= 1) begin
          ser_done = 1'b1;
          serBusy  = 1'b0;
        end else begin
          serCnt = serCnt - 1;
        end
      end
      if (ser_load && !serNever) begin
        serBusy = 1'b1;
        serCnt  = serDelay;
      end
    end
  end

  // Safety net in case the sequence below ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitRoundStart(input int budget, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cycles++;
      if (round_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitSerLoad(input int budget, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cycles++;
      if (ser_load) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic writeMotor(input int m, input logic [10:0] thr, input logic tlm);
    wr_en       = 1'b1;
    wr_addr     = MW'(m);
    wr_throttle = thr;
    wr_tlm      = tlm;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int m = 0; m < NUM_MOTORS; m++) begin
      writeMotor(m, v.thr[m], v.tlm[m]);
    end
    arm = v.armBit;
  endtask

  task automatic captureLoad(input int m, input logic [15:0] expPkt, input string tag);
    bit seen;
    int cyc;
    waitSerLoad(60, seen, cyc);
    checkOutput($sformatf("%s.loadSeen%0d", tag, m), 32'(seen), 32'd1);
    checkOutput($sformatf("%s.motorSel%0d", tag, m), 32'(motor_sel), 32'(m));
    checkOutput($sformatf("%s.serData%0d", tag, m), 32'(ser_data), 32'(expPkt));
  endtask

  task automatic captureLoads(input logic [3:0][15:0] expPkt, input string tag);
    for (int m = 0; m < NUM_MOTORS; m++) begin
      captureLoad(m, expPkt[m], tag);
    end
  endtask

  // Main directed sequence.
  initial begin
    bit               seen;
    int               cyc;
    logic [3:0][15:0] newExp;
    logic [3:0][15:0] zeros;

    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_throttle = '0;
    wr_tlm      = 1'b0;
    arm         = 1'b1;
    enable      = 1'b1;
    err_clear   = 1'b0;
    serDelay    = 5;
    serNever    = 1'b0;
    zeros       = '0;

    vecs[0] = '{thr: {11'd0, 11'd0, 11'd0, 11'd1046}, tlm: 4'b0000, armBit: 1'b1,
                expPkt: {16'h0000, 16'h0000, 16'h0000, 16'h82C6}};
    vecs[1] = '{thr: {11'd1, 11'd2047, 11'd48, 11'd1046}, tlm: 4'b1100, armBit: 1'b1,
                expPkt: {16'h0033, 16'hFFFF, 16'h0606, 16'h82C6}};
    vecs[2] = '{thr: {11'd1, 11'd2047, 11'd48, 11'd1046}, tlm: 4'b1100, armBit: 1'b0,
                expPkt: {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[3] = '{thr: {11'd1365, 11'd1024, 11'd47, 11'd2000}, tlm: 4'b0011, armBit: 1'b1,
                expPkt: {16'hAAAA, 16'h8008, 16'h05FA, 16'hFA14}};

    repeat (3) @(negedge clock);
    checkOutput("rst.serLoad", 32'(ser_load), 32'd0);
    checkOutput("rst.serData", 32'(ser_data), 32'd0);
    checkOutput("rst.motorSel", 32'(motor_sel), 32'd0);
    checkOutput("rst.roundStart", 32'(round_start), 32'd0);
    checkOutput("rst.overrun", 32'(overrun), 32'd0);
    checkOutput("rst.timeoutErr", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Table of rounds: load all shadows, then check every packet of the next round.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      waitRoundStart(120, seen, cyc);
      checkOutput($sformatf("vec%0d.roundSeen", i), 32'(seen), 32'd1);
      captureLoads(vecs[i].expPkt, $sformatf("vec%0d", i));
    end

    // A write during a round only takes effect from the following round.
    waitRoundStart(120, seen, cyc);
    checkOutput("midWr.roundSeen", 32'(seen), 32'd1);
    captureLoad(0, vecs[3].expPkt[0], "midWr");
    writeMotor(1, 11'd100, 1'b0);
    for (int m = 1; m < NUM_MOTORS; m++) begin
      captureLoad(m, vecs[3].expPkt[m], "midWr");
    end
    newExp    = vecs[3].expPkt;
    newExp[1] = 16'h0C84;
    waitRoundStart(120, seen, cyc);
    checkOutput("nextRnd.roundSeen", 32'(seen), 32'd1);
    captureLoads(newExp, "nextRnd");

    // Slow serializer stretches the round past one period: flag set, one tick skipped.
    repeat (3) @(negedge clock);
    checkOutput("ovr.before", 32'(overrun), 32'd0);
    serDelay = 9;
    waitRoundStart(120, seen, cyc);
    checkOutput("ovr.firstSeen", 32'(seen), 32'd1);
    waitRoundStart(150, seen, cyc);
    checkOutput("ovr.secondSeen", 32'(seen), 32'd1);
    checkOutput("ovr.skipTick", 32'(cyc), 32'd100);
    serDelay = 5;
    checkOutput("ovr.flag", 32'(overrun), 32'd1);
    checkOutput("ovr.noTimeout", 32'(timeout_err), 32'd0);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    checkOutput("ovr.cleared", 32'(overrun), 32'd0);

    // Dropping enable lets the current round finish but starts no new one.
    waitRoundStart(120, seen, cyc);
    checkOutput("en.roundSeen", 32'(seen), 32'd1);
    enable = 1'b0;
    captureLoads(newExp, "en");
    waitRoundStart(110, seen, cyc);
    checkOutput("en.noNewRound", 32'(seen), 32'd0);
    enable = 1'b1;

    // Silent serializer: timeout flag eleven clocks after load, then the next motor.
    serNever = 1'b1;
    waitRoundStart(120, seen, cyc);
    checkOutput("to.roundSeen", 32'(seen), 32'd1);
    waitSerLoad(20, seen, cyc);
    checkOutput("to.loadSeen", 32'(seen), 32'd1);
    checkOutput("to.motor0", 32'(motor_sel), 32'd0);
    repeat (10) @(negedge clock);
    checkOutput("to.notYet", 32'(timeout_err), 32'd0);
    @(negedge clock);
    checkOutput("to.flag", 32'(timeout_err), 32'd1);
    waitSerLoad(20, seen, cyc);
    checkOutput("to.nextLoadSeen", 32'(seen), 32'd1);
    checkOutput("to.advanceCycles", 32'(cyc), 32'd3);
    checkOutput("to.nextMotor", 32'(motor_sel), 32'd1);
    err_clear = 1'b1;
    @(negedge clock);
    checkOutput("to.cleared", 32'(timeout_err), 32'd0);
    repeat (10) @(negedge clock);
    checkOutput("to.setWins", 32'(timeout_err), 32'd1);
    @(negedge clock);
    checkOutput("to.clearAfter", 32'(timeout_err), 32'd0);
    err_clear = 1'b0;
    serNever  = 1'b0;

    // Asynchronous reset while waiting on motor 2.
    for (int k = 0; k < 6; k++) begin
      waitSerLoad(40, seen, cyc);
      if (!seen || (motor_sel == 2'd2)) begin
        break;
      end
    end
    checkOutput("rstMid.atMotor2", 32'(motor_sel), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("rstMid.serLoad", 32'(ser_load), 32'd0);
    checkOutput("rstMid.motorSel", 32'(motor_sel), 32'd0);
    checkOutput("rstMid.timeoutErr", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    waitRoundStart(120, seen, cyc);
    checkOutput("rstMid.roundSeen", 32'(seen), 32'd1);
    checkOutput("rstMid.firstTick", 32'(cyc), 32'd50);
    captureLoads(zeros, "rstMid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
